// File: rtl/lvds_tx_pkg.sv
// Shared register map, bus encodings and types for the AHB-Lite LVDS TX bridge.
package lvds_tx_pkg;

  localparam logic [13:0] OFF_CTRL       = 14'h0000;
  localparam logic [13:0] OFF_STATUS     = 14'h0004;
  localparam logic [13:0] OFF_LEN0       = 14'h0010;
  localparam logic [13:0] OFF_LEN1       = 14'h0014;
  localparam logic [13:0] OFF_LEN2       = 14'h0018;
  localparam logic [13:0] OFF_LEN3       = 14'h001C;
  localparam logic [13:0] OFF_BUF_BASE   = 14'h2000;
  localparam logic [13:0] OFF_BUF_STRIDE = 14'h0800;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, RUN} chan_state_e;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  size;
    logic [13:0] off;
  } dphase_t;

  function automatic logic is_len_off(input logic [13:0] off);
    return (off == OFF_LEN0) || (off == OFF_LEN1) || (off == OFF_LEN2) || (off == OFF_LEN3);
  endfunction

endpackage

// File: rtl/lvds_tx_chan.sv
// One EU transmit channel: REQ/ACK handshake with an ACK timeout, then RUN
// until the engine's busy line falls; keeps sticky done/err flags.
module lvds_tx_chan
  import lvds_tx_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic ack,
  input  logic busy,
  output logic req,
  output logic done,
  output logic err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  chan_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy_prev_q;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Clear is applied first so that a same-cycle set of done/err wins.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = done_q;
    err_d   = err_q;
    if (clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (start) begin
      state_d = REQ;
      timer_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        REQ: begin
          timer_d = timer_q + TW'(1);
          if (ack) begin
            state_d = RUN;
          end else if (timer_q == TW'(ACK_TIMEOUT)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        RUN: begin
          if (busy_prev_q && !busy) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      busy_prev_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      busy_prev_q <= busy;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req  = (state_q == REQ);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: rtl/ahblite_lvds_tx_bridge.sv
// AHB-Lite slave giving the CPU the LVDS transmit side for four EUs:
// TX buffer writes, per-EU lengths, start/clear control and status polling.
module ahblite_lvds_tx_bridge
  import lvds_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h4001_0000,
  parameter int          BUF_ADDR_SIZE = 9,
  parameter int          LEN_W         = 10,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [1:0]               HTRANS,
  input  logic                     HREADY,
  input  logic [31:0]              HWDATA,
  output logic [31:0]              HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [BUF_ADDR_SIZE-1:0] TX_BUF_ADDR,
  output logic [31:0]              TX_BUF_WDATA,
  output logic [3:0]               TX_BUF_WE,
  output logic [4*LEN_W-1:0]       TX_LEN,
  output logic [3:0]               TX_REQ,
  input  logic [3:0]               TX_ACK,
  input  logic [3:0]               TX_BUSY
);

  dphase_t          dph_q, dph_d;
  logic             err2_q, err2_d;
  logic [LEN_W-1:0] len_q [4];
  logic [LEN_W-1:0] len_d [4];

  logic [3:0]  chan_req, chan_done, chan_err, chan_start, chan_clear, len_zero;
  logic        is_ctrl, is_status, is_len, is_buf;
  logic        size_err, start_bad, err_first, wr_ok;
  logic [1:0]  len_idx;
  logic [31:0] status_word;

  always_comb begin
    dph_d = '0;
    if (HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) &&
        HADDR[31:14] == BASE_ADDR[31:14]) begin
      dph_d.valid = 1'b1;
      dph_d.write = HWRITE;
      dph_d.size  = HSIZE;
      dph_d.off   = HADDR[13:0];
    end
  end

  // Start legality depends on HWDATA, so the first ERROR cycle is decided in the data phase.
  always_comb begin
    is_ctrl   = dph_q.valid && (dph_q.off == OFF_CTRL);
    is_status = dph_q.valid && (dph_q.off == OFF_STATUS);
    is_len    = dph_q.valid && is_len_off(dph_q.off);
    is_buf    = dph_q.valid && (dph_q.off >= OFF_BUF_BASE);
    len_idx   = dph_q.off[3:2];
    for (int n = 0; n < 4; n++) len_zero[n] = (len_q[n] == '0);
    size_err  = (is_ctrl || is_status || is_len || is_buf) && (dph_q.size != HSIZE_WORD);
    start_bad = is_ctrl && dph_q.write && |(HWDATA[3:0] & (chan_req | TX_BUSY | len_zero));
    err_first = size_err || start_bad;
    wr_ok     = dph_q.write && !err_first;
    err2_d    = err_first;

    chan_start = '0;
    chan_clear = '0;
    if (is_ctrl && wr_ok) begin
      chan_start = HWDATA[3:0];
      chan_clear = HWDATA[11:8] & ~HWDATA[3:0];
    end

    len_d = len_q;
    if (is_len && wr_ok) len_d[len_idx] = HWDATA[LEN_W-1:0];

    TX_BUF_WE    = '0;
    TX_BUF_ADDR  = '0;
    TX_BUF_WDATA = '0;
    if (is_buf && wr_ok) begin
      TX_BUF_WE    = 4'b0001 << dph_q.off[12:11];
      TX_BUF_ADDR  = dph_q.off[BUF_ADDR_SIZE+1:2];
      TX_BUF_WDATA = HWDATA;
    end
  end

  always_comb begin
    status_word = '0;
    for (int n = 0; n < 4; n++)
      status_word[8*(3-n) +: 8] = {5'b0, chan_err[n], chan_done[n], TX_BUSY[n] | chan_req[n]};

    HRDATA = '0;
    if (dph_q.valid && !dph_q.write && !err_first) begin
      if (is_status)   HRDATA = status_word;
      else if (is_len) HRDATA = 32'(len_q[len_idx]);
    end

    TX_LEN = '0;
    for (int n = 0; n < 4; n++) TX_LEN[n*LEN_W +: LEN_W] = len_q[n];
  end

  assign HREADYOUT = !err_first;
  assign HRESP     = (err_first || err2_q) ? HRESP_ERROR : HRESP_OKAY;
  assign TX_REQ    = chan_req;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dph_q  <= '0;
      err2_q <= 1'b0;
      for (int n = 0; n < 4; n++) len_q[n] <= '0;
    end else begin
      dph_q  <= dph_d;
      err2_q <= err2_d;
      len_q  <= len_d;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_chan
    lvds_tx_chan #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_chan (
      .clk   (HCLK),
      .rst   (HRESET),
      .start (chan_start[n]),
      .clear (chan_clear[n]),
      .ack   (TX_ACK[n]),
      .busy  (TX_BUSY[n]),
      .req   (chan_req[n]),
      .done  (chan_done[n]),
      .err   (chan_err[n])
    );
  end

endmodule

// File: tb/tb_ahblite_lvds_tx_bridge.sv
// Scoreboard bench for ahblite_lvds_tx_bridge: bus expectations are queued when a
// transfer is driven and checked when its data phase completes.
module tb_ahblite_lvds_tx_bridge;

  localparam logic [31:0] BASE = 32'h4001_0000;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP;
  logic [8:0]  TX_BUF_ADDR;
  logic [31:0] TX_BUF_WDATA;
  logic [3:0]  TX_BUF_WE, TX_REQ, TX_ACK, TX_BUSY;
  logic [39:0] TX_LEN;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    bit          isErr;
    bit          isRead;
    logic [31:0] rdata;
    logic [3:0]  we;
    logic [8:0]  bufAddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t expQ[$];

  always #5 HCLK = ~HCLK;

  // Single slave on the bus: the matrix ready is this slave's ready.
  assign HREADY = HREADYOUT;

  ahblite_lvds_tx_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .TX_BUF_ADDR(TX_BUF_ADDR), .TX_BUF_WDATA(TX_BUF_WDATA), .TX_BUF_WE(TX_BUF_WE),
    .TX_LEN(TX_LEN), .TX_REQ(TX_REQ), .TX_ACK(TX_ACK), .TX_BUSY(TX_BUSY)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One single-beat transfer; buffer strobes are predicted from the address.
  task automatic applyStimulus(input string tag, input bit wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               input bit expErr, input logic [31:0] expRd);
    exp_t e, got;
    e.tag = tag; e.isErr = expErr; e.isRead = !wr; e.rdata = expRd;
    e.we = '0; e.bufAddr = '0; e.wdata = wdata;
    if (wr && !expErr && addr[13]) begin
      e.we      = 4'b0001 << addr[12:11];
      e.bufAddr = addr[10:2];
    end
    expQ.push_back(e);

    @(negedge HCLK);
    HSEL = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    #1;
    got = expQ.pop_front();
    checkOutput({got.tag, "/ready"}, 64'(HREADYOUT), got.isErr ? 64'd0 : 64'd1);
    checkOutput({got.tag, "/resp"}, 64'(HRESP), 64'(got.isErr));
    if (got.isRead) checkOutput({got.tag, "/rdata"}, 64'(HRDATA), 64'(got.rdata));
    checkOutput({got.tag, "/bufwe"}, 64'(TX_BUF_WE), 64'(got.we));
    if (got.we != 4'b0000) begin
      checkOutput({got.tag, "/bufaddr"}, 64'(TX_BUF_ADDR), 64'(got.bufAddr));
      checkOutput({got.tag, "/bufdata"}, 64'(TX_BUF_WDATA), 64'(got.wdata));
    end
    if (got.isErr) begin
      @(negedge HCLK);
      #1;
      checkOutput({got.tag, "/ready2"}, 64'(HREADYOUT), 64'd1);
      checkOutput({got.tag, "/resp2"}, 64'(HRESP), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b010;
    HTRANS = 2'b00; HWDATA = '0; TX_ACK = '0; TX_BUSY = '0;
    repeat (2) @(negedge HCLK);
    #1;
    checkOutput("rst/hreadyout", 64'(HREADYOUT), 64'd1);
    checkOutput("rst/hresp", 64'(HRESP), 64'd0);
    checkOutput("rst/hrdata", 64'(HRDATA), 64'd0);
    checkOutput("rst/txreq", 64'(TX_REQ), 64'd0);
    checkOutput("rst/txlen", 64'(TX_LEN), 64'd0);
    checkOutput("rst/bufwe", 64'(TX_BUF_WE), 64'd0);
    HRESET = 1'b0;

    // Buffer path: EU2 word 1, strobe lasts a single cycle, reads return 0
    applyStimulus("bufw", 1, BASE + 32'h2804, 3'b010, 32'hA5A5_0001, 0, 0);
    @(posedge HCLK); #1;
    checkOutput("bufw/we_off", 64'(TX_BUF_WE), 64'd0);
    applyStimulus("bufrd", 0, BASE + 32'h2000, 3'b010, 0, 0, 0);

    // Start handshake on EU3
    applyStimulus("len3w", 1, BASE + 32'h18, 3'b010, 32'd16, 0, 0);
    applyStimulus("len3r", 0, BASE + 32'h18, 3'b010, 0, 0, 32'd16);
    checkOutput("txlen3", 64'(TX_LEN), 64'd16 << 20);
    applyStimulus("start3", 1, BASE + 32'h0, 3'b010, 32'h4, 0, 0);
    @(negedge HCLK); #1;
    checkOutput("start3/req", 64'(TX_REQ), 64'h4);
    repeat (2) @(negedge HCLK);
    TX_ACK = 4'b0100;
    @(negedge HCLK);
    TX_ACK = 4'b0000;
    #1;
    checkOutput("start3/reqdrop", 64'(TX_REQ), 64'h0);
    TX_BUSY = 4'b0100;
    applyStimulus("stat_busy3", 0, BASE + 32'h4, 3'b010, 0, 0, 32'h0000_0100);
    repeat (18) @(negedge HCLK);
    TX_BUSY = 4'b0000;
    @(negedge HCLK);
    applyStimulus("stat_done3", 0, BASE + 32'h4, 3'b010, 0, 0, 32'h0000_0200);

    // ACK timeout on EU1
    applyStimulus("len1w", 1, BASE + 32'h10, 3'b010, 32'd8, 0, 0);
    applyStimulus("start1", 1, BASE + 32'h0, 3'b010, 32'h1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge HCLK);
      if (TX_REQ[0]) cnt++;
      else if (cnt > 0) break;
    end
    checkOutput("tmo/cycles", 64'(cnt), 64'd256);
    applyStimulus("stat_err1", 0, BASE + 32'h4, 3'b010, 0, 0, 32'h0400_0200);
    applyStimulus("clr1", 1, BASE + 32'h0, 3'b010, 32'h100, 0, 0);
    applyStimulus("stat_clr1", 0, BASE + 32'h4, 3'b010, 0, 0, 32'h0000_0200);

    // Illegal start while EU2 busy; the clear of EU3 in the same write must not apply
    TX_BUSY = 4'b0010;
    applyStimulus("badstart", 1, BASE + 32'h0, 3'b010, 32'h403, 1, 0);
    @(negedge HCLK); #1;
    checkOutput("badstart/req", 64'(TX_REQ), 64'h0);
    applyStimulus("stat_bad", 0, BASE + 32'h4, 3'b010, 0, 0, 32'h0001_0200);
    TX_BUSY = 4'b0000;
    applyStimulus("start4_len0", 1, BASE + 32'h0, 3'b010, 32'h8, 1, 0);
    checkOutput("start4_len0/req", 64'(TX_REQ), 64'h0);

    // Size errors and unmapped access
    applyStimulus("len1_byte", 1, BASE + 32'h10, 3'b000, 32'h55, 1, 0);
    applyStimulus("len1r", 0, BASE + 32'h10, 3'b010, 0, 0, 32'd8);
    applyStimulus("unmapped", 0, BASE + 32'h100, 3'b010, 0, 0, 0);
    applyStimulus("stat_half", 0, BASE + 32'h4, 3'b001, 0, 1, 0);

    // Start EU4 and clear EU3 in one write
    applyStimulus("len4w", 1, BASE + 32'h1C, 3'b010, 32'd5, 0, 0);
    applyStimulus("start4", 1, BASE + 32'h0, 3'b010, 32'h408, 0, 0);
    @(negedge HCLK); #1;
    checkOutput("start4/req", 64'(TX_REQ), 64'h8);
    applyStimulus("stat_req4", 0, BASE + 32'h4, 3'b010, 0, 0, 32'h0000_0001);

    // Reset while EU4 requests
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK); #1;
    checkOutput("midrst/txreq", 64'(TX_REQ), 64'h0);
    checkOutput("midrst/txlen", 64'(TX_LEN), 64'h0);
    HRESET = 1'b0;
    applyStimulus("midrst/status", 0, BASE + 32'h4, 3'b010, 0, 0, 0);
    applyStimulus("midrst/len3", 0, BASE + 32'h18, 3'b010, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahblite_lvds_tx_bridge.md
Name: ahblite_lvds_tx_bridge

Overview:
AHB-Lite slave that gives the CPU the transmit side of the LVDS link for four execution units (EU1..EU4). The CPU writes word data into four per-EU TX buffers and programs per-EU transfer lengths. It then launches transmissions through a REQ/ACK handshake with each LVDS TX engine and polls per-EU busy, done and error status. It sits on the AHB-Lite matrix beside the LVDS RX bridge, at its own base address.

Parameters:
BASE_ADDR, 32'h4001_0000, block base address; decoded window is BASE_ADDR..BASE_ADDR+0x3FFF
BUF_ADDR_SIZE, 9, word-address width of each EU TX buffer (512 words = 0x800 bytes)
LEN_W, 10, width of each length register
ACK_TIMEOUT, 255, cycles allowed from request to ACK before the request is abandoned

Ports:
HCLK  in  1  clock
HRESET  in  1  reset; synchronous, active-high
HSEL  in  1  slave select
HADDR  in  32  address
HWRITE  in  1  write/read
HSIZE  in  3  transfer size
HTRANS  in  2  transfer type
HREADY  in  1  bus ready
HWDATA  in  32  write data (data phase)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
TX_BUF_ADDR  out  BUF_ADDR_SIZE  buffer word address
TX_BUF_WDATA  out  32  buffer write data
TX_BUF_WE  out  4  one-hot buffer write strobe; bit n = EU n+1
TX_LEN  out  4*LEN_W  packed per-EU lengths; EU1 in the LSBs
TX_REQ  out  4  start request per EU
TX_ACK  in  1*4  per-EU: TX engine has accepted the request
TX_BUSY  in  4  per-EU: TX engine transmitting

Behaviour:
- Reset (HRESET=1 at a HCLK edge): HRDATA=0, HREADYOUT=1, HRESP=0, TX_BUF_WE=0, TX_BUF_ADDR=0, TX_BUF_WDATA=0, TX_LEN=0, TX_REQ=0. Clears done, err, timers and any latched address phase. Reset mid-transfer abandons the transfer and any pending REQ.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Latch HADDR offset, HWRITE and HSIZE. Otherwise latch an idle phase.
- Map (offset from BASE_ADDR):
  - 0x000 CTRL (write-only): bits[3:0] start EUn, bits[11:8] clear done/err EUn.
  - 0x004 STATUS (read-only): byte n = {5'b0, err, done, busy|req}, EU1 in byte 3.
  - 0x010/0x014/0x018/0x01C LEN EU1..4: read/write, LSB LEN_W bits.
  - 0x2000-0x3FFF buffers: write-only, EUn at 0x2000+(n-1)*0x800. Reads return 0.
- Data phase, OKAY path: zero wait states, HREADYOUT=1, HRDATA valid in the same cycle. Unmapped addresses return OKAY, read 0, and writes are ignored.
- Buffer write: during the data phase drive TX_BUF_ADDR=(offset&0x7FF)>>2, TX_BUF_WDATA=HWDATA and TX_BUF_WE one-hot for exactly 1 cycle.
- ERROR response is always two cycles: {HREADYOUT=0, HRESP=1}, then {HREADYOUT=1, HRESP=1}. It is used for:
  - HSIZE != 3'b010 to any mapped register or buffer;
  - a CTRL write starting EUn while req[n], TX_BUSY[n] or LEN[n]==0 holds.
  A rejected CTRL write changes no EU state, including its clear bits.
- Start accepted: req[n] <= 1, done[n] <= 0, timer[n] <= 0. Clear bits apply to non-started EUs in the same write.
- Per-EU FSM:
  - IDLE -> REQ on accepted start.
  - REQ: TX_REQ[n]=1, timer[n] increments.
    - TX_ACK[n]=1 -> RUN, TX_REQ drops on the next edge.
    - timer==ACK_TIMEOUT with no ACK -> IDLE and err[n] <= 1.
    - ACK on the timeout cycle: ACK wins.
  - RUN -> IDLE on a TX_BUSY[n] falling edge (registered busy_d=1, busy=0), setting done[n] <= 1.
- done and err are sticky. They are cleared by a CTRL clear bit or by the next accepted start. A clear coinciding with a done-set edge: set wins.
- LEN writes take effect immediately. Writing LEN while RUN is allowed; the engine has already sampled TX_LEN at ACK.

Decomposition:
- Package lvds_tx_pkg:
  - offset constants CTRL/STATUS/LEN0..3/BUF_BASE/BUF_STRIDE;
  - FSM state enum {IDLE, REQ, RUN};
  - HTRANS and HRESP encodings.
- Sub-module lvds_tx_chan (one per EU, generate ×4): REQ/RUN FSM, timeout counter, busy edge detect, done/err flags.
- The top holds AHB decode, the error FSM and the LEN registers.

Test Plan:
- Buffer write: write 0xA5A5_0001 to BASE+0x2804 -> 1 cycle later TX_BUF_WE=4'b0010, TX_BUF_ADDR=1, TX_BUF_WDATA=0xA5A5_0001; HREADYOUT stays 1.
- Start handshake: LEN EU3=16, write CTRL=0x4 -> TX_REQ[2]=1; ACK after 3 cycles drops REQ. Pulse BUSY high for 20 cycles then low -> STATUS byte1=0x02.
- Timeout: start EU1 with ACK held 0 -> TX_REQ[0] drops after 256 cycles; STATUS byte3=0x04; write CTRL=0x100 -> byte3=0x00.
- Illegal start: write CTRL=0x3 while EU2 is busy -> two-cycle ERROR; EU1 TX_REQ stays 0.
- Byte write: HSIZE=0 to LEN EU1 -> ERROR, LEN unchanged. HSIZE=2 read of unmapped 0x100 -> OKAY, HRDATA=0.
- Reset mid-REQ: assert HRESET while TX_REQ[3]=1 -> next edge TX_REQ=0, STATUS=0, TX_LEN=0.
